int_img_stream: RTL and testbench
=================================

INT_IMG_STREAM -- requirements
Module: int_img_stream

Interface
REQ-001 Parameter WIDTH_LIMIT, default 24, image width in pixels (2..1024).
REQ-002 Parameter HEIGHT_LIMIT, default 24, image height in pixels (2..1024).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 clear  input  1  synchronous frame abort.
REQ-006 in_valid  input  1  pixel present.
REQ-007 in_ready  output  1  block accepts pixel this cycle.
REQ-008 in_pixel  input  8  unsigned grayscale pixel, row-major order.
REQ-009 out_valid  output  1  integral sample present.
REQ-010 out_ready  input  1  consumer accepts sample.
REQ-011 out_ii  output  32  integral image value at (out_y, out_x).
REQ-012 out_ii_sq  output  32  squared integral image value at (out_y, out_x).
REQ-013 out_x  output  10  column of sample; out_y  output  10  row of sample.
REQ-014 out_last  output  1  sample is final pixel of frame.
REQ-015 frame_done  output  1  one-cycle pulse, frame fully delivered.

Function
REQ-016 Accept pixel when in_valid && in_ready; emit sample when out_valid && out_ready.
REQ-017 out_ii(y,x) = sum of in_pixel over rows 0..y, cols 0..x; out_ii_sq the same over in_pixel squared; both modulo 2^32.
REQ-018 Implicit zero padding: row -1 and column -1 contribute 0; no padding samples are emitted.
REQ-019 Internals: running row sums (32-bit, sq 32-bit) plus one row buffer of WIDTH_LIMIT entries each for ii and ii_sq holding the previous row.
REQ-020 ii(y,x) = rowsum(y,x) + buf[x] if y>0, else rowsum(y,x); buf[x] then overwritten with ii(y,x); same for sq.
REQ-021 Latency: sample for accepted pixel is valid the cycle after acceptance (one output register stage).
REQ-022 in_ready = (state != DRAIN) && (!out_valid || out_ready); full throughput, one pixel per cycle without backpressure.
REQ-023 Output holds all fields stable while out_valid && !out_ready.
REQ-024 Column counter wraps to 0 after WIDTH_LIMIT-1, clearing row sums; row counter increments on wrap.
REQ-025 FSM states IDLE, ACTIVE, DRAIN.
REQ-026 IDLE -> ACTIVE on first accepted pixel; ACTIVE -> DRAIN when pixel (HEIGHT_LIMIT-1, WIDTH_LIMIT-1) accepted.
REQ-027 DRAIN: in_ready=0; on out_last handshake -> IDLE, frame_done=1 for exactly that next cycle, counters and row sums zero.
REQ-028 A single-pixel frame is not supported (WIDTH_LIMIT, HEIGHT_LIMIT >= 2).
REQ-029 clear=1: same effect as reset on state, counters, row sums, out_valid, in the next cycle; a pixel offered the same cycle is not accepted (in_ready=0 while clear=1).
REQ-030 clear and rst_n both asserted: reset governs; result identical.
REQ-031 Row buffer contents need no reset; row 0 never reads it.

Reset
REQ-032 On rising edge with rst_n=0: state=IDLE, counters=0, row sums=0, out_valid=0, out_ii=0, out_ii_sq=0, out_x=0, out_y=0, out_last=0, frame_done=0.
REQ-033 in_ready=0 while rst_n=0; 1 first cycle after release.
REQ-034 Reset mid-frame discards partial frame; no frame_done is generated.

Verification
REQ-035 4x4 frame all pixels 2, out_ready=1 -> 16 samples, (3,3) ii=32 ii_sq=64, (0,3) ii=8, (3,0) ii=8; out_last on 16th; frame_done one cycle later.
REQ-036 24x24 all 255 -> final ii=146880, ii_sq=37454400, out_x=23, out_y=23.
REQ-037 4x4 ramp pixel=y*4+x with random out_ready stalls -> sample sequence matches golden model, no drops/duplicates, outputs stable while stalled.
REQ-038 Two back-to-back 4x4 frames (all 1 then all 3) -> second frame (0,0) ii=3, (3,3) ii=48; no carry from first frame.
REQ-039 clear asserted after 6 pixels, then new 4x4 all-1 frame -> (3,3) ii=16, ii_sq=16; no frame_done for aborted frame.
REQ-040 rst_n low 1 cycle mid-row -> all outputs at reset values next cycle; subsequent frame correct.

Source files
------------

// File: rtl/int_img_stream.sv
// int_img_stream: streaming integral image and squared integral image generator.
// One row buffer per sum holds the previous row's integral values.
module int_img_stream #(
   parameter int WIDTH_LIMIT  = 24,
   parameter int HEIGHT_LIMIT = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_pixel,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_ii,
   output logic [31:0] out_ii_sq,
   output logic [9:0]  out_x,
   output logic [9:0]  out_y,
   output logic        out_last,
   output logic        frame_done
);
   localparam int AW = (WIDTH_LIMIT > 1) ? $clog2(WIDTH_LIMIT) : 1;
   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
   state_t state;
   logic [AW-1:0] col;
   logic [9:0] row;
   logic [31:0] rs, rs_sq, rs_n, rs_sq_n, ii_n, ii_sq_n;
   logic [31:0] row_ii [WIDTH_LIMIT];
   logic [31:0] row_sq [WIDTH_LIMIT];
   logic accept, col_end, frame_end;
   always_comb begin
      in_ready  = rst_n && !clear && state != DRAIN && (!out_valid || out_ready);
      accept    = in_valid && in_ready;
      col_end   = col == AW'(WIDTH_LIMIT - 1);
      frame_end = col_end && row == 10'(HEIGHT_LIMIT - 1);
      rs_n      = rs + 32'(in_pixel);
      rs_sq_n   = rs_sq + 32'(in_pixel) * 32'(in_pixel);
      ii_n      = rs_n + (row != 10'd0 ? row_ii[col] : 32'd0);
      ii_sq_n   = rs_sq_n + (row != 10'd0 ? row_sq[col] : 32'd0);
   end
   // Row buffer is write-before-use on row 0, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         row_ii[col] <= ii_n;
         row_sq[col] <= ii_sq_n;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         rs         <= '0;
         rs_sq      <= '0;
         out_valid  <= 1'b0;
         out_ii     <= '0;
         out_ii_sq  <= '0;
         out_x      <= '0;
         out_y      <= '0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (accept) begin
            out_valid <= 1'b1;
            out_ii    <= ii_n;
            out_ii_sq <= ii_sq_n;
            out_x     <= 10'(col);
            out_y     <= row;
            out_last  <= frame_end;
            col       <= col_end ? '0 : col + 1'b1;
            rs        <= col_end ? '0 : rs_n;
            rs_sq     <= col_end ? '0 : rs_sq_n;
            row       <= frame_end ? '0 : col_end ? row + 1'b1 : row;
            state     <= frame_end ? DRAIN : ACTIVE;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (state == DRAIN && out_valid && out_ready && out_last) begin
            state      <= IDLE;
            frame_done <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_int_img_stream.sv
// tb_int_img_stream: directed checks of int_img_stream on a 4x4 and a 24x24 instance.
module tb_int_img_stream;
   logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
   logic iv, ir, ov, ordy, ol, fd;
   logic [7:0] px;
   logic [31:0] ii, sq;
   logic [9:0] ox, oy;
   logic iv24, ir24, ov24, ordy24, ol24, fd24;
   logic [7:0] px24;
   logic [31:0] ii24, sq24;
   logic [9:0] ox24, oy24;
   int n_cmp = 0, n_err = 0, fd_cnt = 0;
   int pix [16];
   logic [31:0] got_ii [16];
   logic [31:0] got_sq [16];

   int_img_stream #(.WIDTH_LIMIT(4), .HEIGHT_LIMIT(4)) u4 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv), .in_ready(ir), .in_pixel(px),
      .out_valid(ov), .out_ready(ordy), .out_ii(ii), .out_ii_sq(sq), .out_x(ox), .out_y(oy),
      .out_last(ol), .frame_done(fd));

   int_img_stream u24 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv24), .in_ready(ir24), .in_pixel(px24),
      .out_valid(ov24), .out_ready(ordy24), .out_ii(ii24), .out_ii_sq(sq24), .out_x(ox24),
      .out_y(oy24), .out_last(ol24), .frame_done(fd24));

   always #5 clk = ~clk;
   always @(posedge clk) if (fd) fd_cnt <= fd_cnt + 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Direct double sum over the rectangle, independent of any running-sum scheme.
   function automatic logic [31:0] model(input int y, input int x, input bit s);
      logic [31:0] a = 0;
      for (int r = 0; r <= y; r++)
         for (int c = 0; c <= x; c++)
            a += s ? 32'(pix[r*4+c] * pix[r*4+c]) : 32'(pix[r*4+c]);
      return a;
   endfunction

   task automatic fill(input int v, input bit ramp);
      for (int i = 0; i < 16; i++) pix[i] = ramp ? i : v;
   endtask

   task automatic run_frame(input bit stall);
      int sent = 0, rcv = 0, cyc = 0;
      bit held = 0;
      logic [85:0] cur, snap, e;
      while (rcv < 16 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         cur = {ov, ii, sq, ox, oy, ol};
         if (held) chk("hold", cur, snap);
         ordy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         iv = sent < 16;
         if (sent < 16) px = 8'(pix[sent]);
         #1;
         held = ov && !ordy;
         snap = cur;
         if (ov && ordy) begin
            e = {1'b1, model(rcv/4, rcv%4, 0), model(rcv/4, rcv%4, 1), 10'(rcv%4), 10'(rcv/4), rcv == 15};
            chk($sformatf("sample%0d", rcv), cur, e);
            got_ii[rcv] = ii;
            got_sq[rcv] = sq;
            rcv++;
         end
         if (iv && ir) sent++;
      end
      chk("frame_count", rcv, 16);
      @(negedge clk);
      iv = 1'b0;
      ordy = 1'b1;
      chk("done_high", {fd, ov}, 2'b10);
      @(negedge clk);
      chk("done_low", fd, 0);
   endtask

   task automatic send_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         iv = 1'b1;
         px = 8'(pix[i]);
         ordy = 1'b1;
         #1;
         chk("partial_ready", ir, 1);
      end
      @(negedge clk);
      iv = 1'b0;
   endtask

   initial begin
      int base;
      bit found = 0;
      iv = 0; px = 0; ordy = 1; iv24 = 0; px24 = 0; ordy24 = 1;
      repeat (2) @(negedge clk);
      chk("reset_out", {ov, ii, sq, ox, oy, ol, fd}, 0);
      chk("reset_ready", ir, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_release", ir, 1);

      fill(2, 0);
      run_frame(0);
      chk("ii_3_3", got_ii[15], 32);
      chk("sq_3_3", got_sq[15], 64);
      chk("ii_0_3", got_ii[3], 8);
      chk("ii_3_0", got_ii[12], 8);
      chk("done_count1", fd_cnt, 1);

      fill(0, 1);
      run_frame(1);
      chk("ramp_ii_3_3", got_ii[15], 120);
      chk("ramp_sq_3_3", got_sq[15], 1240);

      fill(1, 0);
      run_frame(0);
      fill(3, 0);
      run_frame(0);
      chk("b2b_ii_0_0", got_ii[0], 3);
      chk("b2b_ii_3_3", got_ii[15], 48);
      chk("done_count2", fd_cnt, 4);

      fill(1, 0);
      send_n(6);
      base = fd_cnt;
      @(negedge clk);
      clear = 1'b1;
      iv = 1'b1;
      #1;
      chk("clear_ready", ir, 0);
      @(negedge clk);
      clear = 1'b0;
      iv = 1'b0;
      chk("clear_out", {ov, ii, sq, ox, oy, ol, fd}, 0);
      repeat (3) @(negedge clk);
      chk("clear_no_done", fd_cnt, base);
      run_frame(0);
      chk("clr_ii_3_3", got_ii[15], 16);
      chk("clr_sq_3_3", got_sq[15], 16);

      send_n(6);
      base = fd_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_out", {ov, ii, sq, ox, oy, ol, fd}, 0);
      chk("midrst_ready", ir, 0);
      rst_n = 1'b1;
      fill(5, 0);
      run_frame(0);
      chk("rst_ii_3_3", got_ii[15], 80);
      chk("rst_sq_3_3", got_sq[15], 400);
      chk("rst_done_count", fd_cnt, base + 1);

      iv24 = 1'b1;
      px24 = 8'd255;
      for (int c = 0; c < 700 && !found; c++) begin
         @(negedge clk);
         if (ov24 && ol24) begin
            found = 1;
            iv24 = 1'b0;
         end
      end
      chk("big_found", found, 1);
      chk("big_last", {ii24, sq24, ox24, oy24}, {32'd146880, 32'd37454400, 10'd23, 10'd23});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
